// File: rtl/puzzle_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : puzzle_move_ctrl                                           |
// | Description : 8-puzzle move engine over a shared 40-bit register file.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module puzzle_move_ctrl #(
  parameter int IDEAL_IDX = 1,
  parameter int PATH_IDX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  dir_i,
  input  logic [4:0]  src_idx_i,
  input  logic [4:0]  dst_idx_i,
  input  logic        clr_path_i,
  output logic [4:0]  rf_src0_o,
  output logic [4:0]  rf_src1_o,
  input  logic [39:0] rf_data0_i,
  input  logic [39:0] rf_data1_i,
  output logic [4:0]  rf_dst_o,
  output logic        rf_we_o,
  output logic [39:0] rf_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        illegal_o,
  output logic        solved_o
);

  localparam logic [4:0] PATH_ADDR  = 5'(PATH_IDX);
  localparam logic [4:0] IDEAL_ADDR = 5'(IDEAL_IDX);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_EVAL     = 3'd2,
    S_WR_BOARD = 3'd3,
    S_WR_PATH  = 3'd4,
    S_DONE     = 3'd5,
    S_CLR      = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [4:0]  src_q, src_d;
  logic [4:0]  dst_q, dst_d;
  logic [39:0] board_q, board_d;
  logic [39:0] path_q, path_d;
  logic [39:0] goal_q, goal_d;
  logic [39:0] newb_q, newb_d;
  logic        illegal_q, illegal_d;
  logic        solved_q, solved_d;

  logic [3:0]  w_blank;
  logic [3:0]  w_depth;
  logic [1:0]  w_col;
  logic [3:0]  w_target;
  logic        w_move_bad;
  logic        w_illegal;
  logic [3:0]  w_moved;
  logic [39:0] w_new_board;
  logic [39:0] w_new_path;

  assign w_blank = board_q[39:36];
  assign w_depth = path_q[33:30];

  // Column of the blank; 3 flags an out-of-range blank position.
  always_comb begin
    case (w_blank)
      4'd0, 4'd3, 4'd6: w_col = 2'd0;
      4'd1, 4'd4, 4'd7: w_col = 2'd1;
      4'd2, 4'd5, 4'd8: w_col = 2'd2;
      default:          w_col = 2'd3;
    endcase
  end

  always_comb begin
    w_target   = 4'd0;
    w_move_bad = 1'b0;
    case (dir_q)
      2'b00: begin
        w_move_bad = (w_blank < 4'd3);
        w_target   = w_blank - 4'd3;
      end
      2'b01: begin
        w_move_bad = (w_blank > 4'd5);
        w_target   = w_blank + 4'd3;
      end
      2'b10: begin
        w_move_bad = (w_col == 2'd0);
        w_target   = w_blank - 4'd1;
      end
      default: begin
        w_move_bad = (w_col == 2'd2);
        w_target   = w_blank + 4'd1;
      end
    endcase
  end

  assign w_illegal = (w_blank > 4'd8) | w_move_bad | (w_depth == 4'hF) |
                     (dst_q == PATH_ADDR) | (dst_q == IDEAL_ADDR);

  // Tile position p lives at bits [35-4p -: 4]; the target tile slides into the blank.
  always_comb begin
    w_moved = 4'd0;
    for (int p = 0; p < 9; p++) begin
      if (w_target == 4'(p)) w_moved = board_q[35-4*p -: 4];
    end
    w_new_board = {w_target, 36'd0};
    for (int p = 0; p < 9; p++) begin
      if (w_target == 4'(p))     w_new_board[35-4*p -: 4] = 4'd0;
      else if (w_blank == 4'(p)) w_new_board[35-4*p -: 4] = w_moved;
      else                       w_new_board[35-4*p -: 4] = board_q[35-4*p -: 4];
    end
  end

  always_comb begin
    w_new_path = {6'd0, w_depth + 4'd1, path_q[29:0]};
    for (int k = 0; k < 15; k++) begin
      if (w_depth == 4'(k)) w_new_path[2*k +: 2] = dir_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    src_d      = src_q;
    dst_d      = dst_q;
    board_d    = board_q;
    path_d     = path_q;
    goal_d     = goal_q;
    newb_d     = newb_q;
    illegal_d  = illegal_q;
    solved_d   = solved_q;
    rf_src0_o  = 5'd0;
    rf_src1_o  = 5'd0;
    rf_dst_o   = 5'd0;
    rf_we_o    = 1'b0;
    rf_wdata_o = 40'd0;
    done_o     = 1'b0;
    busy_o     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dir_d     = dir_i;
          src_d     = src_idx_i;
          dst_d     = dst_idx_i;
          illegal_d = 1'b0;
          solved_d  = 1'b0;
          state_d   = S_RD;
        end else if (clr_path_i) begin
          illegal_d = 1'b0;
          solved_d  = 1'b0;
          state_d   = S_CLR;
        end
      end
      S_RD: begin
        rf_src0_o = src_q;
        rf_src1_o = PATH_ADDR;
        board_d   = rf_data0_i;
        path_d    = rf_data1_i;
        state_d   = S_EVAL;
      end
      S_EVAL: begin
        rf_src1_o = IDEAL_ADDR;
        goal_d    = rf_data1_i;
        newb_d    = w_new_board;
        if (w_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d   = S_WR_BOARD;
        end
      end
      S_WR_BOARD: begin
        rf_we_o    = 1'b1;
        rf_dst_o   = dst_q;
        rf_wdata_o = newb_q;
        state_d    = S_WR_PATH;
      end
      S_WR_PATH: begin
        rf_we_o    = 1'b1;
        rf_dst_o   = PATH_ADDR;
        rf_wdata_o = w_new_path;
        solved_d   = (newb_q == goal_q);
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_CLR: begin
        rf_we_o  = 1'b1;
        rf_dst_o = PATH_ADDR;
        done_o   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dir_q     <= 2'd0;
      src_q     <= 5'd0;
      dst_q     <= 5'd0;
      board_q   <= 40'd0;
      path_q    <= 40'd0;
      goal_q    <= 40'd0;
      newb_q    <= 40'd0;
      illegal_q <= 1'b0;
      solved_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      board_q   <= board_d;
      path_q    <= path_d;
      goal_q    <= goal_d;
      newb_q    <= newb_d;
      illegal_q <= illegal_d;
      solved_q  <= solved_d;
    end
  end

  assign illegal_o = illegal_q;
  assign solved_o  = solved_q;

endmodule
`default_nettype wire

// File: doc/puzzle_move_ctrl.md
PUZZLE_MOVE_CTRL -- requirements
Module: puzzle_move_ctrl

Interface
REQ-001 SHALL have parameter IDEAL_IDX, default 1, register index holding the goal board.
REQ-002 SHALL have parameter PATH_IDX, default 4, register index holding the move-path word.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  move request; sampled only in IDLE.
REQ-006 dir  input  2  move of blank: 00 up (-3), 01 down (+3), 10 left (-1), 11 right (+1).
REQ-007 src_idx / dst_idx  input  5 each  register holding the current board / register receiving the new board.
REQ-008 clr_path  input  1  in IDLE, zero the path register; start has priority if both are high.
REQ-009 rf_src0 / rf_src1  output  5 each  register-file read addresses.
REQ-010 rf_data0 / rf_data1  input  40 each  combinational read data for rf_src0 / rf_src1.
REQ-011 rf_dst  output  5, rf_we  output  1, rf_wdata  output  40  register-file write port.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at the end of each request.
REQ-014 illegal / solved  output  1 each  result flags, held from done until the next accepted start or clr_path.

Function
REQ-015 Board format SHALL be: [39:36] blank position 0..8; tile at position p in bits [35-4p : 32-4p].
REQ-016 Path format SHALL be: [33:30] depth; move k in [2k+1:2k]; [39:34] zero.
REQ-017 FSM states SHALL be IDLE, RD, EVAL, WR_BOARD, WR_PATH, DONE, CLR.
REQ-018 IDLE: if start=1 at edge T, SHALL latch dir, src_idx and dst_idx, clear illegal and solved, and enter RD. Otherwise, if clr_path=1, SHALL enter CLR.
REQ-019 RD: SHALL drive rf_src0=src_idx and rf_src1=PATH_IDX, and capture the board and path at the cycle end.
REQ-020 EVAL: SHALL drive rf_src1=IDEAL_IDX, capture the goal board, and compute the legality and the new board.
REQ-021 A move SHALL be illegal if any of these hold: blank>8; up with blank<3; down with blank>5; left with blank%3=0; right with blank%3=2; depth=15; dst_idx equals PATH_IDX or IDEAL_IDX.
REQ-022 From EVAL, an illegal move SHALL go to DONE with illegal=1 and no writes; a legal move SHALL go to WR_BOARD.
REQ-023 New board: the tile at the target position q SHALL move to the old blank position, position q SHALL become 0, and [39:36]=q.
REQ-024 WR_BOARD: SHALL assert rf_we=1, rf_dst=dst_idx, rf_wdata=new board for exactly one cycle.
REQ-025 WR_PATH: SHALL assert rf_we=1, rf_dst=PATH_IDX, and write the path with dir inserted at slot = old depth and depth+1, for exactly one cycle.
REQ-026 solved SHALL be set at WR_PATH when the new board equals the captured goal word exactly (all 40 bits).
REQ-027 DONE: done=1 for one cycle, then IDLE.
REQ-028 CLR: SHALL write 40'h0 to PATH_IDX for one cycle, pulse done in the same cycle, then go to IDLE.
REQ-029 Latency from the start edge T: a legal move SHALL pulse done in cycle T+5; an illegal move in cycle T+3.
REQ-030 start during busy SHALL be ignored and not queued.
REQ-031 When no write is in progress, rf_we, rf_dst and rf_wdata SHALL be 0; rf_src0 and rf_src1 SHALL be 0 in IDLE.
REQ-032 src_idx=dst_idx SHALL be permitted (in-place move).

Reset
REQ-033 With rst_n=0 at an edge: state SHALL be IDLE, and busy, done, illegal, solved, rf_we, rf_dst, rf_wdata, rf_src0, rf_src1 SHALL all be 0.
REQ-034 Reset mid-operation SHALL abort with no further writes, including while in WR_BOARD or WR_PATH.

Verification
REQ-035 Board 0x5_1234_5078_6, path 0, dir=01 -> board written 0x8_1234_5678_0, then path 0x00_4000_0001; solved=1 and done in T+5.
REQ-036 Same board, dir=11 -> illegal=1, done in T+3, rf_we never high.
REQ-037 Same board, dir=00 -> board written 0x2_1204_5378_6, solved=0, depth 1, path[1:0]=00.
REQ-038 Path with depth=15 and any legal dir -> illegal=1, no writes; then clr_path -> path register becomes 0 and done pulses once.
REQ-039 Assert rst_n=0 in WR_BOARD -> WR_PATH never occurs, the path is unchanged, and all outputs are 0 next cycle.
REQ-040 start held high for 10 cycles -> exactly two accepted requests, done pulses only at T+5 and T+11.
